pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the 5-stage pipeline: PC register, hard-wired incrementer and next-PC selection in one block. It feeds the instruction-memory address in IF and accepts branch redirects from EX/MEM and jumps from ID. A taken branch arriving during a stall is latched and applied when the stall releases. An optional return-address stack predicts return targets.

## Interface
- `PC_WIDTH`, 32, width of PC and all target buses
- `PC_STEP`, 1, increment per sequential fetch (word-addressed memory)
- `RESET_VECTOR`, 0, PC value after reset
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2); used only with `PC_RAS_EN`
- `Clk` in 1: rising-edge clock
- `Reset` in 1: asynchronous, active-high reset
- `Stall` in 1: hold PC (hazard unit)
- `BranchTaken` in 1: taken branch resolved downstream
- `BranchTarget` in PC_WIDTH: branch destination
- `Jump` in 1: unconditional jump from ID
- `JumpTarget` in PC_WIDTH: jump destination; also fallback target for `Return`
- `Call` in 1: jump-and-link qualifier, valid only with `Jump`
- `Return` in 1: return qualifier, valid only with `Jump`
- `PC` out PC_WIDTH: current fetch address (registered)
- `PCAddResult` out PC_WIDTH: PC + PC_STEP (combinational)
- `RedirectPending` out 1: latched branch awaiting stall release
- `RasEmpty` out 1: RAS holds no entries
- `RasFull` out 1: RAS holds RAS_DEPTH entries

## Operation
- Reset values: PC=RESET_VECTOR, RedirectPending=0, pending target=0, RAS count=0, RasEmpty=1, RasFull=0.
- Arithmetic is modulo 2^PC_WIDTH. PC+STEP wraps silently; e.g. all-ones + 1 → 0.
- Stall=1:
  - PC holds.
  - Jump, Call and Return are ignored; ID is stalled and re-presents them.
  - BranchTaken=1 latches BranchTarget into the pending register and sets RedirectPending. A newer branch overwrites an older pending target.
- Stall=0, next-PC priority:
  1. BranchTaken → BranchTarget. Clears any pending redirect; the live branch wins.
  2. RedirectPending → pending target. Clears pending.
  3. Jump&Return → RAS top if RAS non-empty, else JumpTarget. Pops the RAS.
  4. Jump (incl. Call) → JumpTarget. Call pushes PCAddResult.
  5. Otherwise → PCAddResult.
- RAS side effects happen only when the Jump path is selected. If a branch or pending redirect wins, there is no push or pop.
- RAS is circular:
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty leaves state unchanged.
  - Call and Return together replace the top entry: pop then push, count unchanged. Next PC comes from the pre-pop top, or JumpTarget if empty.
- Call or Return without Jump has no effect.

## Timing
- All state updates occur on the rising Clk edge. Reset acts immediately, independent of Clk.
- Redirect latency is 1 cycle: a target presented in cycle n appears on PC in cycle n+1.
- Pending branch: applied in the first cycle with Stall=0, visible on PC at the following edge.
- PCAddResult settles combinationally from PC with no added cycle.
- Reset mid-operation discards the pending redirect and all RAS contents. The first edge after Reset deasserts yields RESET_VECTOR+STEP, unless Stall or a redirect is active.

## Configuration
- `PC_RAS_EN` defined: RAS of RAS_DEPTH×PC_WIDTH is built, and Return uses it as described.
- `PC_RAS_EN` undefined:
  - No RAS storage is built; Call is ignored.
  - Jump&Return → JumpTarget.
  - RasEmpty is tied to 1 and RasFull to 0.
- All other behaviour is identical in both builds.

## Test plan
- **Reset and sequential fetch:** Reset=1, then release with no controls. Expect PC = 0,1,2,3 on consecutive edges. Reset asserted mid-run forces PC=0 asynchronously.
- **Stall capture:** Stall=1 for 3 cycles with PC=0x10. Apply BranchTaken with target 0x40 in stall cycle 1, then 0x80 in stall cycle 2. Expect PC held at 0x10 and RedirectPending=1. After release, PC=0x80 and RedirectPending=0.
- **Priority:** Stall=0, BranchTaken(0x100) together with Jump(0x200) and a pending 0x300. Expect PC=0x100, pending cleared, no RAS change.
- **RAS call/return (PC_RAS_EN, depth 4):**
  - Five Calls from PC=0x10,0x20,0x30,0x40,0x50 → RasFull=1.
  - Four Returns yield 0x51,0x41,0x31,0x21; the oldest entry was overwritten.
  - RasEmpty=1 after the fourth Return.
  - A fifth Return with JumpTarget 0x99 → PC=0x99.
- **Without PC_RAS_EN:** Call then Return (JumpTarget 0x77) → PC=0x77; RasEmpty=1 and RasFull=0 throughout.
- **Wrap-around:** PC_WIDTH=8, PC=0xFF, no controls → PC=0x00 next cycle.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: PC register, incrementer and next-PC select with stall-latched branch redirect.
// Define PC_RAS_EN to build the circular return-address stack used by Jump&Return.
module pc_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  PC_STEP      = 1,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] JumpTarget,
  input  logic                Call,
  input  logic                Return,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCAddResult,
  output logic                RedirectPending,
  output logic                RasEmpty,
  output logic                RasFull
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                pend_vld_q, pend_vld_d;
  logic                jump_sel;
  logic [PC_WIDTH-1:0] jump_pc;

  assign PC              = pc_q;
  assign PCAddResult     = pc_q + PC_WIDTH'(PC_STEP);
  assign RedirectPending = pend_vld_q;

  // A live branch beats a pending one; ID controls are ignored while stalled.
  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    jump_sel   = 1'b0;
    if (Stall) begin
      if (BranchTaken) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = BranchTarget;
      end
    end else if (BranchTaken) begin
      pc_d       = BranchTarget;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      pc_d       = pend_tgt_q;
      pend_vld_d = 1'b0;
    end else if (Jump) begin
      pc_d     = jump_pc;
      jump_sel = 1'b1;
    end else begin
      pc_d = PCAddResult;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_VECTOR;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int SPW = $clog2(RAS_DEPTH);
  localparam int CW  = SPW + 1;

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [SPW-1:0]      sp_q, sp_d, sp_pop;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_pop;
  logic                ras_push, ras_pop;
  logic [PC_WIDTH-1:0] ras_top;

  // sp_q points at the next free slot; when full that slot holds the oldest entry.
  assign ras_top  = ras_q[sp_q - SPW'(1)];
  assign RasEmpty = (cnt_q == '0);
  assign RasFull  = (cnt_q == CW'(RAS_DEPTH));
  assign jump_pc  = (Return && !RasEmpty) ? ras_top : JumpTarget;
  assign ras_pop  = jump_sel & Return;
  assign ras_push = jump_sel & Call;

  always_comb begin
    sp_pop  = sp_q;
    cnt_pop = cnt_q;
    if (ras_pop && !RasEmpty) begin
      sp_pop  = sp_q - SPW'(1);
      cnt_pop = cnt_q - CW'(1);
    end
    sp_d  = sp_pop;
    cnt_d = cnt_pop;
    if (ras_push) begin
      sp_d = sp_pop + SPW'(1);
      if (cnt_pop != CW'(RAS_DEPTH)) cnt_d = cnt_pop + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (ras_push) ras_q[sp_pop] <= PCAddResult;
  end
`else
  logic ras_unused;

  assign jump_pc    = JumpTarget;
  assign RasEmpty   = 1'b1;
  assign RasFull    = 1'b0;
  assign ras_unused = Call & Return & jump_sel & (RAS_DEPTH >= 2);
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized + directed stimulus against a queue-based reference model,
// expectations checked by an independent monitor every cycle.
module tb_pc_unit;
  localparam int W     = 8;
  localparam int STEP  = 1;
  localparam int DEPTH = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0, Call = 1'b0, Return = 1'b0;
  logic [W-1:0] BranchTarget = '0, JumpTarget = '0;
  logic [W-1:0] PC, PCAddResult;
  logic         RedirectPending, RasEmpty, RasFull;

  pc_unit #(.PC_WIDTH(W), .PC_STEP(STEP), .RESET_VECTOR(8'h00), .RAS_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Call(Call), .Return(Return), .PC(PC), .PCAddResult(PCAddResult),
    .RedirectPending(RedirectPending), .RasEmpty(RasEmpty), .RasFull(RasFull)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] pc;
    logic         pend;
    logic         empty;
    logic         full;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;

  // Reference state: PC, pending redirect, and the return stack as a bounded queue.
  logic [W-1:0] m_pc, m_tgt;
  logic         m_pend;
  logic [W-1:0] m_ras[$];

  task automatic model_reset();
    m_pc   = 8'h00;
    m_pend = 1'b0;
    m_tgt  = 8'h00;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] add, nxt;
    add = m_pc + 8'(STEP);
    if (Stall) begin
      if (BranchTaken) begin
        m_pend = 1'b1;
        m_tgt  = BranchTarget;
      end
    end else if (BranchTaken) begin
      m_pc   = BranchTarget;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end else if (Jump) begin
      nxt = JumpTarget;
`ifdef PC_RAS_EN
      if (Return && m_ras.size() > 0) begin
        nxt = m_ras[$];
        void'(m_ras.pop_back());
      end
      if (Call) begin
        m_ras.push_back(add);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
`endif
      m_pc = nxt;
    end else begin
      m_pc = add;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pc   = m_pc;
    e.pend = m_pend;
`ifdef PC_RAS_EN
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
`else
    e.empty = 1'b1;
    e.full  = 1'b0;
`endif
    return e;
  endfunction

  // rst_mode: 0 none, 1 short async pulse inside the low phase, 2 hold Reset across the edge
  task automatic step(input logic st, input logic bt, input logic [W-1:0] bta,
                      input logic jp, input logic [W-1:0] jta,
                      input logic cl, input logic rt, input int rst_mode);
    @(negedge Clk);
    Stall = st; BranchTaken = bt; BranchTarget = bta;
    Jump = jp; JumpTarget = jta; Call = cl; Return = rt;
    if (rst_mode == 2) begin
      Reset = 1'b1;
      model_reset();
    end else begin
      Reset = 1'b0;
      if (rst_mode == 1) begin
        #1 Reset = 1'b1;
        #1 Reset = 1'b0;
        model_reset();
      end
      model_step();
    end
    sb.push_back(model_out());
    pushed++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk("pc",      PC,                      e.pc);
        chk("pc_add",  PCAddResult,             e.pc + 8'(STEP));
        chk("pending", {7'd0, RedirectPending}, {7'd0, e.pend});
        chk("empty",   {7'd0, RasEmpty},        {7'd0, e.empty});
        chk("full",    {7'd0, RasFull},         {7'd0, e.full});
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    model_reset();
    // Reset hold, then sequential fetch 1,2,3,4
    step(0, 0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 2);
    idle(4);
    // Short async reset pulse between edges mid-run
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Stall capture: newer branch overwrites older pending target
    step(0, 1, 8'h10, 0, 0, 0, 0, 0);
    step(1, 1, 8'h40, 0, 0, 0, 0, 0);
    step(1, 1, 8'h80, 1, 8'h55, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Priority: live branch beats pending redirect and jump+call
    step(1, 1, 8'h30, 0, 0, 0, 0, 0);
    step(0, 1, 8'h11, 1, 8'h22, 1, 0, 0);
    idle(1);
    // Five calls from 0x10..0x50, then five returns
    step(0, 1, 8'h10, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) step(0, 0, 0, 1, 8'(i * 16), 1, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 1, 8'h99, 0, 1, 0);
    // Call then Return, and call+return together
    step(0, 0, 0, 1, 8'h60, 1, 0, 0);
    step(0, 0, 0, 1, 8'h77, 0, 1, 0);
    step(0, 0, 0, 1, 8'h20, 1, 0, 0);
    step(0, 0, 0, 1, 8'h33, 1, 1, 0);
    step(0, 0, 0, 1, 8'h44, 0, 1, 0);
    // Call/Return without Jump do nothing
    step(0, 0, 0, 0, 8'h12, 1, 0, 0);
    step(0, 0, 0, 0, 8'h12, 0, 1, 0);
    // Wrap-around at 0xFF
    step(0, 1, 8'hFE, 0, 0, 0, 0, 0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 127);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 8'($urandom),
           ($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           (r == 0) ? 2 : ((r < 3) ? 1 : 0));
    end
    @(posedge Clk);
    #3;
    checks++;
    if (popped != pushed || sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: popped %0d want %0d", popped, pushed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
